// File: rtl/seq_lock_pkg.sv
// Shared types and elaboration-time helpers for the seq_lock code detector.
package seq_lock_pkg;

    // Widest packed code: 16 symbols of up to 4 bits each.
    localparam int CODE_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        DONE    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    // Symbol width for a given number of buttons, never below one bit.
    function automatic int calc_sym_w(input int n_btn);
        int w;
        w = $clog2(n_btn);
        return (w < 1) ? 1 : w;
    endfunction

    // Progress width: must hold 0..seq_len inclusive.
    function automatic int calc_pw(input int seq_len);
        return $clog2(seq_len + 1);
    endfunction

    // Counter width able to hold 0..max_val, never below one bit.
    function automatic int calc_cnt_w(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Symbol idx of the packed code, zero-extended to 4 bits.
    function automatic logic [3:0] code_sym(input logic [CODE_MAX_W-1:0] code,
                                            input int sym_w, input int idx);
        logic [CODE_MAX_W-1:0] sh;
        sh = code >> (idx * sym_w);
        return sh[3:0] & 4'((1 << sym_w) - 1);
    endfunction

    // True when code[0..k-2] equals code[p-k+1..p-1], i.e. the first k-1
    // symbols of the code reappear at the tail of the p already-matched ones.
    function automatic bit code_border(input logic [CODE_MAX_W-1:0] code,
                                       input int sym_w, input int p, input int k);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < k - 1; i++) begin
            if (code_sym(code, sym_w, i) != code_sym(code, sym_w, p - k + 1 + i)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/seq_lock_next.sv
// Combinational next-progress generator: extends the match when the symbol
// fits, otherwise falls back to the longest code prefix that is still a
// suffix of the entered symbols (overlap-aware, KMP-style).
module seq_lock_next
    import seq_lock_pkg::*;
#(
    parameter int                    SEQ_LEN = 4,
    parameter int                    SYM_W   = 1,
    parameter logic [CODE_MAX_W-1:0] CODE    = 64'b0010
) (
    input  logic [calc_pw(SEQ_LEN)-1:0] p,
    input  logic [SYM_W-1:0]            s,
    output logic [calc_pw(SEQ_LEN)-1:0] nxt
);
    localparam int PW = calc_pw(SEQ_LEN);

    // ext[pp]: symbol extends a match of length pp.
    // cand[pp][k]: symbol leaves a k-long prefix matched when coming from pp.
    logic [SEQ_LEN:0]   ext;
    logic [SEQ_LEN-1:0] cand [SEQ_LEN+1];

    for (genvar pp = 0; pp <= SEQ_LEN; pp++) begin : g_pos
        if (pp < SEQ_LEN) begin : g_ext
            localparam logic [SYM_W-1:0] SYM_P = SYM_W'(code_sym(CODE, SYM_W, pp));
            assign ext[pp] = (s == SYM_P);
        end else begin : g_no_ext
            assign ext[pp] = 1'b0;
        end

        assign cand[pp][0] = 1'b0;

        for (genvar k = 1; k < SEQ_LEN; k++) begin : g_k
            if ((k <= pp) && code_border(CODE, SYM_W, pp, k)) begin : g_live
                localparam logic [SYM_W-1:0] SYM_K = SYM_W'(code_sym(CODE, SYM_W, k - 1));
                assign cand[pp][k] = (s == SYM_K);
            end else begin : g_dead
                assign cand[pp][k] = 1'b0;
            end
        end
    end

    // Select the row for the current progress; extension beats any fallback,
    // and among fallbacks the longest prefix wins.
    always_comb begin
        nxt = '0;
        for (int pp = 0; pp <= SEQ_LEN; pp++) begin
            if (p == PW'(pp)) begin
                for (int k = 1; k < SEQ_LEN; k++) begin
                    if (cand[pp][k]) nxt = PW'(k);
                end
                if (ext[pp]) nxt = PW'(pp + 1);
            end
        end
    end

endmodule

// File: rtl/seq_lock.sv
// Keypad code-sequence detector with inter-press timeout, failure counting
// and timed lockout. All outputs are registered.
//
// state   | meaning
// IDLE    | nothing matched (progress = 0)
// ENTRY   | part of the code matched (0 < progress < SEQ_LEN)
// DONE    | whole code matched (progress = SEQ_LEN)
// LOCKOUT | too many failures; presses ignored until the lock timer expires
module seq_lock
    import seq_lock_pkg::*;
#(
    parameter int                    N_BTN          = 2,
    parameter int                    SEQ_LEN        = 4,
    parameter logic [CODE_MAX_W-1:0] CODE           = 64'b0010,
    parameter int                    TIMEOUT_CYCLES = 36_000_000,
    parameter int                    MAX_FAIL       = 3,
    parameter int                    LOCK_CYCLES    = 120_000_000
) (
    input  logic                            hwclk,
    input  logic                            rst,
    input  logic [N_BTN-1:0]                press,
    output logic [calc_pw(SEQ_LEN)-1:0]     progress,
    output logic                            match,
    output logic                            unlocked,
    output logic                            locked_out,
    output logic [calc_cnt_w(MAX_FAIL)-1:0] fail_cnt
);
    localparam int SYM_W = calc_sym_w(N_BTN);
    localparam int PW    = calc_pw(SEQ_LEN);
    localparam int FW    = calc_cnt_w(MAX_FAIL);
    localparam int IW    = calc_cnt_w(TIMEOUT_CYCLES);
    localparam int LW    = calc_cnt_w(LOCK_CYCLES);

    localparam logic [PW-1:0] P_FULL    = PW'(SEQ_LEN);
    localparam logic [FW-1:0] F_MAX     = FW'(MAX_FAIL);
    localparam logic [IW-1:0] IDLE_LOAD = (TIMEOUT_CYCLES > 0) ? IW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [LW-1:0] LOCK_LOAD = (LOCK_CYCLES > 0) ? LW'(LOCK_CYCLES - 1) : '0;

    state_t          state_q, state_d;
    logic [PW-1:0]   progress_q, progress_d;
    logic            match_q, match_d;
    logic            unlocked_q, unlocked_d;
    logic [FW-1:0]   fail_cnt_q, fail_cnt_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [LW-1:0]   lock_cnt_q, lock_cnt_d;

    logic            press_one;
    logic            press_multi;
    logic [SYM_W-1:0] sym;
    logic [PW-1:0]   nxt_prog;
    logic            is_fail;

    // Classify the press vector and encode the single pressed button.
    always_comb begin
        press_one   = (press != '0) && ((press & (press - N_BTN'(1))) == '0);
        press_multi = (press != '0) && !press_one;
        sym         = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (press[i]) sym = SYM_W'(i);
        end
    end

    seq_lock_next #(
        .SEQ_LEN (SEQ_LEN),
        .SYM_W   (SYM_W),
        .CODE    (CODE)
    ) u_next (
        .p   (progress_q),
        .s   (sym),
        .nxt (nxt_prog)
    );

    // Next-state logic: lockout timing, press handling, idle timeout, failures.
    always_comb begin
        state_d    = state_q;
        progress_d = progress_q;
        match_d    = 1'b0;
        unlocked_d = unlocked_q;
        fail_cnt_d = fail_cnt_q;
        idle_cnt_d = idle_cnt_q;
        lock_cnt_d = lock_cnt_q;
        is_fail    = 1'b0;

        if (state_q == LOCKOUT) begin
            // Presses are ignored here, including in the exit cycle.
            if (lock_cnt_q == '0) begin
                fail_cnt_d = '0;
            end else begin
                lock_cnt_d = lock_cnt_q - LW'(1);
            end
        end else if (press_one) begin
            idle_cnt_d = IDLE_LOAD;
            progress_d = nxt_prog;
            unlocked_d = 1'b0;
            if (nxt_prog == P_FULL) begin
                match_d    = 1'b1;
                unlocked_d = 1'b1;
                fail_cnt_d = '0;
            end else if ((progress_q != '0) && (nxt_prog <= progress_q)) begin
                is_fail = 1'b1;
            end
        end else if (press_multi) begin
            progress_d = '0;
            unlocked_d = 1'b0;
            is_fail    = (progress_q != '0);
        end else if ((TIMEOUT_CYCLES > 0) && (progress_q != '0)) begin
            if (idle_cnt_q == '0) begin
                progress_d = '0;
                unlocked_d = 1'b0;
            end else begin
                idle_cnt_d = idle_cnt_q - IW'(1);
            end
        end

        if (is_fail) begin
            if (fail_cnt_q < F_MAX) fail_cnt_d = fail_cnt_q + FW'(1);
            if ((MAX_FAIL > 0) && (fail_cnt_d == F_MAX)) begin
                progress_d = '0;
                unlocked_d = 1'b0;
                lock_cnt_d = LOCK_LOAD;
            end
        end

        // State follows progress except while the lock timer runs.
        if ((state_q == LOCKOUT) && (lock_cnt_q != '0)) begin
            state_d = LOCKOUT;
        end else if (is_fail && (MAX_FAIL > 0) && (fail_cnt_d == F_MAX)) begin
            state_d = LOCKOUT;
        end else if (progress_d == '0) begin
            state_d = IDLE;
        end else if (progress_d == P_FULL) begin
            state_d = DONE;
        end else begin
            state_d = ENTRY;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_q    <= IDLE;
            progress_q <= '0;
            match_q    <= 1'b0;
            unlocked_q <= 1'b0;
            fail_cnt_q <= '0;
            idle_cnt_q <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            progress_q <= progress_d;
            match_q    <= match_d;
            unlocked_q <= unlocked_d;
            fail_cnt_q <= fail_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign progress   = progress_q;
    assign match      = match_q;
    assign unlocked   = unlocked_q;
    assign locked_out = (state_q == LOCKOUT);
    assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_seq_lock.sv
// Bench for seq_lock: two instances (default 2-button code, 4-button 6-symbol
// code), driven from a vector table through an expected-value queue, plus a
// hand-written lockout-duration measurement.
module tb_seq_lock;

    typedef struct {
        bit         d;
        bit         r;
        logic [3:0] pr;
        int         n;
        logic [2:0] p;
        logic       m;
        logic       u;
        logic       l;
        logic [1:0] f;
    } vec_t;

    typedef struct {
        int         idx;
        bit         d;
        logic [2:0] p;
        logic       m;
        logic       u;
        logic       l;
        logic [1:0] f;
    } exp_t;

    localparam logic [3:0] NP = 4'b0000;
    localparam logic [3:0] B0 = 4'b0001;
    localparam logic [3:0] B1 = 4'b0010;
    localparam logic [3:0] BB = 4'b0011;
    localparam logic [3:0] S1 = 4'b0010;
    localparam logic [3:0] S2 = 4'b0100;
    localparam logic [3:0] S3 = 4'b1000;

    logic       hwclk;
    logic       rst0, rst1;
    logic [1:0] press0;
    logic [3:0] press1;
    logic [2:0] prog0, prog1;
    logic       match0, match1, unl0, unl1, lko0, lko1;
    logic [1:0] fc0, fc1;

    vec_t vecs[$];
    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;

    seq_lock #(
        .N_BTN(2), .SEQ_LEN(4), .CODE(64'h2),
        .TIMEOUT_CYCLES(20), .MAX_FAIL(3), .LOCK_CYCLES(10)
    ) u_dut0 (
        .hwclk(hwclk), .rst(rst0), .press(press0), .progress(prog0),
        .match(match0), .unlocked(unl0), .locked_out(lko0), .fail_cnt(fc0)
    );

    seq_lock #(
        .N_BTN(4), .SEQ_LEN(6), .CODE(64'hBDF),
        .TIMEOUT_CYCLES(20), .MAX_FAIL(3), .LOCK_CYCLES(10)
    ) u_dut1 (
        .hwclk(hwclk), .rst(rst1), .press(press1), .progress(prog1),
        .match(match1), .unlocked(unl1), .locked_out(lko1), .fail_cnt(fc1)
    );

    initial begin
        hwclk = 1'b0;
        forever #5 hwclk = ~hwclk;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1);
    end

    function automatic void add(input bit d, input bit r, input logic [3:0] pr, input int n,
                                input int p, input bit m, input bit u, input bit l, input int f);
        vec_t v;
        v.d = d; v.r = r; v.pr = pr; v.n = n;
        v.p = 3'(p); v.m = m; v.u = u; v.l = l; v.f = 2'(f);
        vecs.push_back(v);
    endfunction

    task automatic check_out(input exp_t e);
        logic [2:0] ap;
        logic       am, au, al;
        logic [1:0] af;
        if (e.d == 1'b0) begin
            ap = prog0; am = match0; au = unl0; al = lko0; af = fc0;
        end else begin
            ap = prog1; am = match1; au = unl1; al = lko1; af = fc1;
        end
        tests++;
        if (ap !== e.p || am !== e.m || au !== e.u || al !== e.l || af !== e.f) begin
            fails++;
            $display("FAIL vec%0d dut%0d: got prog=%0d match=%0b unlocked=%0b locked_out=%0b fail_cnt=%0d, expected prog=%0d match=%0b unlocked=%0b locked_out=%0b fail_cnt=%0d",
                     e.idx, e.d, ap, am, au, al, af, e.p, e.m, e.u, e.l, e.f);
        end
    endtask

    initial begin
        int cnt;
        exp_t e;
        rst0 = 1'b1; rst1 = 1'b1; press0 = '0; press1 = '0;

        //  d  r  press n  prog m  u  l  fail
        // reset, including a press during reset
        add(0, 1, B0, 2, 0, 0, 0, 0, 0);
        add(0, 0, NP, 2, 0, 0, 0, 0, 0);
        // 0,1,0,0 spaced three cycles apart
        add(0, 0, B0, 1, 1, 0, 0, 0, 0);
        add(0, 0, NP, 2, 1, 0, 0, 0, 0);
        add(0, 0, B1, 1, 2, 0, 0, 0, 0);
        add(0, 0, NP, 2, 2, 0, 0, 0, 0);
        add(0, 0, B0, 1, 3, 0, 0, 0, 0);
        add(0, 0, NP, 2, 3, 0, 0, 0, 0);
        add(0, 0, B0, 1, 4, 1, 1, 0, 0);
        add(0, 0, NP, 2, 4, 0, 1, 0, 0);
        // overlap 1,0,0 from DONE: press from DONE counts as a failure
        add(0, 0, B1, 1, 2, 0, 0, 0, 1);
        add(0, 0, B0, 1, 3, 0, 0, 0, 1);
        add(0, 0, B0, 1, 4, 1, 1, 0, 0);
        add(0, 0, NP, 1, 4, 0, 1, 0, 0);
        // 0,1,0,1 falls back to 2
        add(0, 1, NP, 1, 0, 0, 0, 0, 0);
        add(0, 0, B0, 1, 1, 0, 0, 0, 0);
        add(0, 0, B1, 1, 2, 0, 0, 0, 0);
        add(0, 0, B0, 1, 3, 0, 0, 0, 0);
        add(0, 0, B1, 1, 2, 0, 0, 0, 1);
        // timeout after 20 idle cycles, failure count kept
        add(0, 0, NP, 19, 2, 0, 0, 0, 1);
        add(0, 0, NP, 1, 0, 0, 0, 0, 1);
        // 19 idle cycles then a press still extends
        add(0, 0, B0, 1, 1, 0, 0, 0, 1);
        add(0, 0, NP, 19, 1, 0, 0, 0, 1);
        add(0, 0, B1, 1, 2, 0, 0, 0, 1);
        // three failures -> lockout for 10 cycles, exit-cycle press ignored
        add(0, 1, NP, 1, 0, 0, 0, 0, 0);
        add(0, 0, B0, 1, 1, 0, 0, 0, 0);
        add(0, 0, B0, 1, 1, 0, 0, 0, 1);
        add(0, 0, B1, 1, 2, 0, 0, 0, 1);
        add(0, 0, B1, 1, 0, 0, 0, 0, 2);
        add(0, 0, B0, 1, 1, 0, 0, 0, 2);
        add(0, 0, B0, 1, 0, 0, 0, 1, 3);
        add(0, 0, B0, 9, 0, 0, 0, 1, 3);
        add(0, 0, B1, 1, 0, 0, 0, 0, 0);
        add(0, 0, B0, 1, 1, 0, 0, 0, 0);
        // multi-press at progress 2
        add(0, 0, B1, 1, 2, 0, 0, 0, 0);
        add(0, 0, BB, 1, 0, 0, 0, 0, 1);
        // reach lockout again, then reset in the middle of it
        add(0, 0, B0, 1, 1, 0, 0, 0, 1);
        add(0, 0, B0, 1, 1, 0, 0, 0, 2);
        add(0, 0, B0, 1, 0, 0, 0, 1, 3);
        add(0, 0, NP, 3, 0, 0, 0, 1, 3);
        add(0, 1, B0, 1, 0, 0, 0, 0, 0);
        add(0, 0, NP, 2, 0, 0, 0, 0, 0);
        // multi-press from DONE clears unlocked
        add(0, 0, B0, 1, 1, 0, 0, 0, 0);
        add(0, 0, B1, 1, 2, 0, 0, 0, 0);
        add(0, 0, B0, 1, 3, 0, 0, 0, 0);
        add(0, 0, B0, 1, 4, 1, 1, 0, 0);
        add(0, 0, BB, 1, 0, 0, 0, 0, 1);
        // timeout from DONE clears unlocked
        add(0, 1, NP, 1, 0, 0, 0, 0, 0);
        add(0, 0, B0, 1, 1, 0, 0, 0, 0);
        add(0, 0, B1, 1, 2, 0, 0, 0, 0);
        add(0, 0, B0, 1, 3, 0, 0, 0, 0);
        add(0, 0, B0, 1, 4, 1, 1, 0, 0);
        add(0, 0, NP, 19, 4, 0, 1, 0, 0);
        add(0, 0, NP, 1, 0, 0, 0, 0, 0);
        // 4 buttons, code 3,3,1,3,3,2
        add(1, 1, NP, 1, 0, 0, 0, 0, 0);
        add(1, 0, S3, 1, 1, 0, 0, 0, 0);
        add(1, 0, S3, 1, 2, 0, 0, 0, 0);
        add(1, 0, S1, 1, 3, 0, 0, 0, 0);
        add(1, 0, S3, 1, 4, 0, 0, 0, 0);
        add(1, 0, S3, 1, 5, 0, 0, 0, 0);
        add(1, 0, S1, 1, 3, 0, 0, 0, 1);
        add(1, 0, S3, 1, 4, 0, 0, 0, 1);
        add(1, 0, S3, 1, 5, 0, 0, 0, 1);
        add(1, 0, S2, 1, 6, 1, 1, 0, 0);
        add(1, 0, NP, 1, 6, 0, 1, 0, 0);
        add(1, 0, S3, 1, 1, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                @(negedge hwclk);
                if (vecs[i].d == 1'b0) begin
                    rst0 = vecs[i].r; press0 = vecs[i].pr[1:0]; press1 = '0;
                end else begin
                    rst1 = vecs[i].r; press1 = vecs[i].pr; press0 = '0;
                end
                e.idx = i; e.d = vecs[i].d; e.p = vecs[i].p; e.m = vecs[i].m;
                e.u = vecs[i].u; e.l = vecs[i].l; e.f = vecs[i].f;
                expq.push_back(e);
                @(posedge hwclk);
                #1;
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard: queue empty at vec%0d, expected one entry", i);
                end else begin
                    check_out(expq.pop_front());
                end
            end
        end
        press1 = '0;

        // Measure how many cycles locked_out stays high after the third failure.
        @(negedge hwclk); rst0 = 1'b1; press0 = '0;
        @(negedge hwclk); rst0 = 1'b0;
        repeat (4) begin
            @(negedge hwclk); press0 = 2'b01;
        end
        @(negedge hwclk); press0 = 2'b00;
        cnt = 0;
        while (lko0 === 1'b1 && cnt < 50) begin
            cnt++;
            @(posedge hwclk);
            #1;
        end
        tests++;
        if (cnt != 10) begin
            fails++;
            $display("FAIL lock_duration: locked_out high for %0d cycles, expected 10", cnt);
        end
        tests++;
        if (fc0 !== 2'd0 || prog0 !== 3'd0) begin
            fails++;
            $display("FAIL lock_exit: fail_cnt=%0d progress=%0d, expected 0 and 0", fc0, prog0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
